// File: rtl/nbit_comparator_sseg.sv
// Unsigned magnitude comparator with a 3-digit multiplexed seven-segment readout:
// digit 0 shows the result letter, digits 1/2 show B/A in hex when SSEG_HEX_EN is defined.
module nbit_comparator_sseg #(
  parameter int WIDTH       = 4,
  parameter int REFRESH_CNT = 48000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             a_gt_b,
  output logic             a_lt_b,
  output logic             a_eq_b,
  output logic             result_chg,
  output logic [2:0]       sseg_en,
  output logic [7:0]       sseg
);

  localparam int CW = (REFRESH_CNT > 2) ? $clog2(REFRESH_CNT) : 1;

  logic [WIDTH-1:0] a_s1_q, a_s1_d, a_s2_q, a_s2_d;
  logic [WIDTH-1:0] b_s1_q, b_s1_d, b_s2_q, b_s2_d;
  logic [1:0]       vld_q, vld_d;
  logic             fvld_q, fvld_d;
  logic [2:0]       flags_q, flags_d;
  logic             chg_q, chg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       dig_q, dig_d;
  logic             acc_q, acc_d;
  logic [1:0]       hist_q, hist_d;
  logic             dp_q, dp_d;
  logic [2:0]       en_q, en_d;
  logic [7:0]       sseg_q, sseg_d;
  logic             wrap;
  logic [7:0]       letter;

`ifdef SSEG_HEX_EN
  function automatic logic [7:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 8'hC0;  4'h1: hex7 = 8'hF9;  4'h2: hex7 = 8'hA4;  4'h3: hex7 = 8'hB0;
      4'h4: hex7 = 8'h99;  4'h5: hex7 = 8'h92;  4'h6: hex7 = 8'h82;  4'h7: hex7 = 8'hF8;
      4'h8: hex7 = 8'h80;  4'h9: hex7 = 8'h90;  4'hA: hex7 = 8'h88;  4'hB: hex7 = 8'h83;
      4'hC: hex7 = 8'hC6;  4'hD: hex7 = 8'hA1;  4'hE: hex7 = 8'h86;  default: hex7 = 8'h8E;
    endcase
  endfunction
`endif

  always_comb begin
    a_s1_d = a;
    b_s1_d = b;
    a_s2_d = a_s1_q;
    b_s2_d = b_s1_q;
    vld_d  = {vld_q[0], 1'b1};
    fvld_d = fvld_q | vld_q[1];

    // Flags stay cleared until the second synchroniser stage holds a sampled value.
    flags_d = flags_q;
    if (vld_q[1])
      flags_d = {a_s2_q > b_s2_q, a_s2_q < b_s2_q, a_s2_q == b_s2_q};
    chg_d = fvld_q && (flags_d != flags_q);

    wrap  = (cnt_q == CW'(REFRESH_CNT - 1));
    cnt_d = wrap ? '0 : cnt_q + CW'(1);
    dig_d = dig_q;
    if (wrap)
      dig_d = (dig_q == 2'd2) ? 2'd0 : dig_q + 2'd1;

    // Per-slot change history; dp for a digit-0 slot covers the three slots just finished.
    acc_d  = wrap ? 1'b0 : (acc_q | chg_q);
    hist_d = wrap ? {hist_q[0], acc_q | chg_q} : hist_q;
    dp_d   = dp_q;
    if (wrap && dig_q == 2'd2)
      dp_d = |{hist_q, acc_q, chg_q};

    case (flags_q)
      3'b100:  letter = 8'hC2;
      3'b010:  letter = 8'hC7;
      3'b001:  letter = 8'h86;
      default: letter = 8'hFF;
    endcase

    en_d   = ~(3'b001 << dig_d);
    sseg_d = 8'hFF;
    case (dig_d)
      2'd0: sseg_d = letter & (dp_d ? 8'h7F : 8'hFF);
`ifdef SSEG_HEX_EN
      2'd1: sseg_d = hex7(4'(b_s2_q));
      2'd2: sseg_d = hex7(4'(a_s2_q));
`else
      2'd1, 2'd2: en_d = 3'b111;
`endif
      default: en_d = 3'b111;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_s1_q  <= '0;
      a_s2_q  <= '0;
      b_s1_q  <= '0;
      b_s2_q  <= '0;
      vld_q   <= '0;
      fvld_q  <= 1'b0;
      flags_q <= '0;
      chg_q   <= 1'b0;
      cnt_q   <= '0;
      dig_q   <= '0;
      acc_q   <= 1'b0;
      hist_q  <= '0;
      dp_q    <= 1'b0;
      en_q    <= 3'b111;
      sseg_q  <= 8'hFF;
    end else begin
      a_s1_q  <= a_s1_d;
      a_s2_q  <= a_s2_d;
      b_s1_q  <= b_s1_d;
      b_s2_q  <= b_s2_d;
      vld_q   <= vld_d;
      fvld_q  <= fvld_d;
      flags_q <= flags_d;
      chg_q   <= chg_d;
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      acc_q   <= acc_d;
      hist_q  <= hist_d;
      dp_q    <= dp_d;
      en_q    <= en_d;
      sseg_q  <= sseg_d;
    end
  end

  assign a_gt_b     = flags_q[2];
  assign a_lt_b     = flags_q[1];
  assign a_eq_b     = flags_q[0];
  assign result_chg = chg_q;
  assign sseg_en    = en_q;
  assign sseg       = sseg_q;

endmodule

// File: tb/tb_nbit_comparator_sseg.sv
// Directed bench for nbit_comparator_sseg with REFRESH_CNT=4, WIDTH=4; edge n counts
// rising edges after reset release, and the digit index after edge n is (n/4)%3.
module tb_nbit_comparator_sseg;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] a, b;
  logic       a_gt_b, a_lt_b, a_eq_b, result_chg;
  logic [2:0] sseg_en;
  logic [7:0] sseg;

  int n_cmp = 0;
  int n_bad = 0;
  int n     = 0;

  nbit_comparator_sseg #(.WIDTH(4), .REFRESH_CNT(4)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b),
    .a_gt_b(a_gt_b), .a_lt_b(a_lt_b), .a_eq_b(a_eq_b), .result_chg(result_chg),
    .sseg_en(sseg_en), .sseg(sseg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, exp, n);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    n++;
    @(negedge clk);
  endtask

  task automatic tick_to(input int t);
    while (n < t) tick();
  endtask

  function automatic logic [7:0] flags();
    return {5'b0, a_gt_b, a_lt_b, a_eq_b};
  endfunction

  initial begin
    rst_n = 1'b0;
    a = 4'h0;
    b = 4'h0;
    repeat (2) @(negedge clk);
    chk("rst_flags", flags(), 8'h00);
    chk("rst_chg", {7'b0, result_chg}, 8'h00);
    chk("rst_en", {5'b0, sseg_en}, 8'h07);
    chk("rst_sseg", sseg, 8'hFF);
    rst_n = 1'b1;

    tick();
    chk("e1_flags", flags(), 8'h00);
    chk("e1_en", {5'b0, sseg_en}, 8'h06);
    chk("e1_sseg", sseg, 8'hFF);
    tick();
    chk("e2_flags", flags(), 8'h00);
    tick();
    chk("e3_eq", flags(), 8'h01);
    chk("e3_chg", {7'b0, result_chg}, 8'h00);
    tick_to(5);
    chk("e5_chg", {7'b0, result_chg}, 8'h00);

    a = 4'hA; b = 4'h3;
    tick_to(7);
    chk("gt_lat2", flags(), 8'h01);
    tick_to(8);
    chk("gt_lat3", flags(), 8'h04);
    chk("gt_chg", {7'b0, result_chg}, 8'h01);
    tick_to(9);
    chk("gt_chg_end", {7'b0, result_chg}, 8'h00);
    tick_to(12);
    chk("gt_en0", {5'b0, sseg_en}, 8'h06);
    chk("gt_dp", sseg, 8'h42);
    tick_to(24);
    chk("gt_nodp", sseg, 8'hC2);

    a = 4'h1; b = 4'hF;
    tick_to(26);
    chk("lt_lat2", flags(), 8'h04);
    tick_to(27);
    chk("lt_flags", flags(), 8'h02);
    chk("lt_chg", {7'b0, result_chg}, 8'h01);
    tick_to(36);
    chk("lt_dp", sseg, 8'h47);
    tick_to(48);
    chk("lt_nodp", sseg, 8'hC7);

    a = 4'h5; b = 4'h2;
    tick_to(51);
    chk("a5b2_flags", flags(), 8'h04);
    tick_to(52);
`ifdef SSEG_HEX_EN
    chk("d1_en", {5'b0, sseg_en}, 8'h05);
    chk("d1_sseg", sseg, 8'hA4);
    tick_to(55);
    chk("d1_en_hold", {5'b0, sseg_en}, 8'h05);
    tick_to(56);
    chk("d2_en", {5'b0, sseg_en}, 8'h03);
    chk("d2_sseg", sseg, 8'h92);
    tick_to(59);
    chk("d2_en_hold", {5'b0, sseg_en}, 8'h03);
`else
    chk("d1_en", {5'b0, sseg_en}, 8'h07);
    chk("d1_sseg", sseg, 8'hFF);
    tick_to(56);
    chk("d2_en", {5'b0, sseg_en}, 8'h07);
    chk("d2_sseg", sseg, 8'hFF);
    tick_to(59);
    chk("d2_en_hold", {5'b0, sseg_en}, 8'h07);
`endif
    tick_to(60);
    chk("d0_en", {5'b0, sseg_en}, 8'h06);
    chk("d0_sseg", sseg, 8'h42);
    tick_to(63);
    chk("d0_en_hold", {5'b0, sseg_en}, 8'h06);
    tick_to(64);
`ifdef SSEG_HEX_EN
    chk("d1_en_again", {5'b0, sseg_en}, 8'h05);
`else
    chk("d1_en_again", {5'b0, sseg_en}, 8'h07);
`endif

    tick_to(65);
    a = 4'h5; b = 4'h5;
    tick_to(68);
    chk("eq_flags", flags(), 8'h01);
    chk("eq_chg", {7'b0, result_chg}, 8'h01);
`ifdef SSEG_HEX_EN
    chk("midslot_en", {5'b0, sseg_en}, 8'h03);
`else
    chk("midslot_en", {5'b0, sseg_en}, 8'h07);
`endif
    tick_to(72);
    chk("eq_en0", {5'b0, sseg_en}, 8'h06);
    chk("eq_dp", sseg, 8'h06);

    tick_to(81);
    rst_n = 1'b0;
    #1;
    chk("arst_en", {5'b0, sseg_en}, 8'h07);
    chk("arst_sseg", sseg, 8'hFF);
    chk("arst_flags", flags(), 8'h00);
    chk("arst_chg", {7'b0, result_chg}, 8'h00);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nbit_comparator_sseg.md
NBIT_COMPARATOR_SSEG -- requirements
Module: nbit_comparator_sseg

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, giving the operand width; legal range 1..4.
REQ-002 SHALL provide parameter REFRESH_CNT, default 48000, giving clocks per digit slot (4 ms at 12 MHz); legal minimum 2.
REQ-003 SHALL provide port clk, input, 1 bit, the single system clock; all state on rising edge.
REQ-004 SHALL provide port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL provide port a, input, WIDTH bits, operand A, unsigned, asynchronous to clk.
REQ-006 SHALL provide port b, input, WIDTH bits, operand B, unsigned, asynchronous to clk.
REQ-007 SHALL provide port a_gt_b, output, 1 bit, registered flag set when A > B.
REQ-008 SHALL provide port a_lt_b, output, 1 bit, registered flag set when A < B.
REQ-009 SHALL provide port a_eq_b, output, 1 bit, registered flag set when A == B.
REQ-010 SHALL provide port result_chg, output, 1 bit, one-cycle pulse when the result class changes.
REQ-011 SHALL provide port sseg_en, output, 3 bits, active-low digit enables; bit 0 is the rightmost digit.
REQ-012 SHALL provide port sseg, output, 8 bits, active-low segments ordered {dp,g,f,e,d,c,b,a}.

Function
REQ-013 SHALL register a and b into a two-flop synchroniser; compare the second stage; register the flags; total latency a/b to flags = 3 clocks.
REQ-014 SHALL keep exactly one of a_gt_b/a_lt_b/a_eq_b high from the fourth clock after reset release onward.
REQ-015 SHALL pulse result_chg for exactly one clock when the registered flag triple differs from its previous value; first valid result after reset SHALL NOT pulse.
REQ-016 SHALL run a scan counter 0..REFRESH_CNT-1; on wrap advance digit index 0->1->2->0; no other state.
REQ-017 SHALL drive exactly one sseg_en bit low per slot, matching digit index; sseg SHALL update in the same cycle as sseg_en.
REQ-018 Digit 0 SHALL show result letter: G = 8'hC2, L = 8'hC7, E = 8'h86.
REQ-019 Digit 0 dp SHALL be lit (sseg[7]=0) for the whole slot following any result_chg pulse within the previous full scan (3 slots), else off.
REQ-020 Digits 1 and 2 SHALL follow REQ-030/REQ-031.
REQ-021 Operands narrower than 4 bits SHALL be zero-extended for display.
REQ-022 Operand changes mid-slot SHALL not restart the scan counter or digit index.

Reset
REQ-023 On rst_n low, a_gt_b, a_lt_b, a_eq_b, result_chg SHALL be 0 immediately (asynchronous).
REQ-024 On rst_n low, sseg_en SHALL be 3'b111, sseg 8'hFF, scan counter 0, digit index 0, synchroniser and history registers 0.
REQ-025 After release, first digit enable SHALL assert on the first clock edge with digit index 0.
REQ-026 Reset asserted mid-slot SHALL blank the display within the same cycle, without waiting for a clock.

Configuration
REQ-027 SHALL use macro SSEG_HEX_EN to compile the operand display in or out.
REQ-028 With SSEG_HEX_EN defined, digit 1 SHALL show synchronised B as hex and digit 2 synchronised A as hex.
REQ-029 Hex codes SHALL be standard active-low: 0=C0, 1=F9, 2=A4, 3=B0, 5=92, A=88, F=8E.
REQ-030 Without SSEG_HEX_EN, digits 1 and 2 slots SHALL still be scanned, but with sseg_en=3'b111 and sseg=8'hFF.
REQ-031 Flag outputs and timing SHALL be identical in both builds.

Verification (REFRESH_CNT=4, WIDTH=4)
REQ-032 Reset held, then a=0,b=0, release: flags 0,0,0 for 3 clocks, then a_eq_b=1; result_chg stays 0.
REQ-033 a=4'hA,b=4'h3 after stable eq: a_gt_b=1 exactly 3 clocks later; result_chg pulses 1 clock; next digit-0 slot sseg=8'h42 (G with dp).
REQ-034 a=4'h1,b=4'hF: a_lt_b=1; digit-0 slot sseg=8'hC7 after dp window expires.
REQ-035 HEX build, a=4'h5,b=4'h2: slot sequence sseg_en 110/101/011 with sseg G-code, A4, 92; each slot 4 clocks.
REQ-036 Non-HEX build, same stimulus: slots 1 and 2 give sseg_en=111, sseg=FF; flags identical to HEX build.
REQ-037 rst_n low mid-slot 2: sseg_en=111, sseg=FF, flags 0 before next clk edge.
